truth_table_sweeper: RTL

//  Upstream stimulus/capture stage for a 3-input combinational gate block (e.g. a 0x9A-class logic module).

---
 rtl/sweeper_pkg.sv | 17 +
 rtl/sample_voter.sv | 29 ++
 rtl/truth_table_sweeper.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int unsigned N_IN_DEF = 3;
    localparam int unsigned TT_W     = 2 ** N_IN_DEF;
    localparam int unsigned NSAMP    = 3;
    localparam int unsigned SCNT_W   = 8;
    localparam int unsigned SAMP_W   = 2;

endpackage

// File: rtl/sample_voter.sv
// Three-sample shift register with majority vote and unanimity check.
module sample_voter
    import sweeper_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic shift_en,
    input  logic din,
    output logic vote,
    output logic disagree
);

    logic [NSAMP-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sr[NSAMP-2:0], din};
        end
    end

    assign vote     = (sr[0] & sr[1]) | (sr[0] & sr[2]) | (sr[1] & sr[2]);
    assign disagree = (|sr) & ~(&sr);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input code of a small gate, votes three samples per code and
// compares the measured truth table against a reference.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned           N_IN     = 3,
    parameter int unsigned           SETTLE   = 4,
    parameter logic [(2**N_IN)-1:0]  EXPECTED = 8'h9A
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   gate_out,
    output logic [N_IN-1:0]        gate_in,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   table_out,
    output logic                   match,
    output logic                   glitch
);

    localparam int unsigned TT_WL = 2 ** N_IN;

    state_t              state, state_nxt;
    logic [SCNT_W-1:0]   settle_cnt, settle_cnt_d;
    logic [SAMP_W-1:0]   samp_cnt, samp_cnt_d;
    logic [N_IN-1:0]     code_d;
    logic [TT_WL-1:0]    shadow, shadow_d;
    logic                sflag, sflag_d;
    logic                wr_pend, wr_pend_d;
    logic [N_IN-1:0]     wr_idx, wr_idx_d, wr_bit;
    logic                busy_d, done_d, match_d, glitch_d;
    logic [TT_WL-1:0]    table_d;
    logic                last_samp, last_code;
    logic                vclr, vshift, vote, disagree;

    assign last_samp = (samp_cnt == SAMP_W'(NSAMP - 1));
    assign last_code = (gate_in == N_IN'(TT_WL - 1));
    assign wr_bit    = N_IN'(TT_WL - 1) - wr_idx;

    sample_voter u_voter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (vclr),
        .shift_en (vshift),
        .din      (gate_out),
        .vote     (vote),
        .disagree (disagree)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort wins over everything outside IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start && !abort) state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (settle_cnt == '0) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (last_samp) state_nxt = last_code ? ST_DONE : ST_SETTLE;
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath / output next values. The vote of a code is committed one
    // cycle after its third sample, so DONE folds the last pending bit in.
    always_comb begin
        settle_cnt_d = settle_cnt;
        samp_cnt_d   = samp_cnt;
        code_d       = gate_in;
        shadow_d     = shadow;
        sflag_d      = sflag;
        wr_pend_d    = 1'b0;
        wr_idx_d     = wr_idx;
        busy_d       = (state_nxt != ST_IDLE);
        done_d       = 1'b0;
        table_d      = table_out;
        match_d      = match;
        glitch_d     = glitch;
        vclr         = 1'b0;
        vshift       = 1'b0;

        if (wr_pend) begin
            shadow_d[wr_bit] = vote;
            sflag_d          = sflag | disagree;
        end

        case (state)
            ST_IDLE: begin
                if (state_nxt == ST_SETTLE) begin
                    settle_cnt_d = SCNT_W'(SETTLE - 1);
                    samp_cnt_d   = '0;
                    code_d       = '0;
                    shadow_d     = '0;
                    sflag_d      = 1'b0;
                    vclr         = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt != '0) settle_cnt_d = settle_cnt - SCNT_W'(1);
                samp_cnt_d = '0;
            end
            ST_SAMPLE: begin
                vshift     = 1'b1;
                samp_cnt_d = samp_cnt + SAMP_W'(1);
                if (last_samp) begin
                    wr_pend_d    = 1'b1;
                    wr_idx_d     = gate_in;
                    samp_cnt_d   = '0;
                    code_d       = last_code ? '0 : gate_in + N_IN'(1);
                    settle_cnt_d = SCNT_W'(SETTLE - 1);
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                table_d  = shadow_d;
                match_d  = (shadow_d == EXPECTED);
                glitch_d = sflag_d;
                code_d   = '0;
            end
            default: ;
        endcase

        // Aborted sweeps leave the published result untouched
        if (abort && (state != ST_IDLE)) begin
            code_d    = '0;
            wr_pend_d = 1'b0;
            done_d    = 1'b0;
            table_d   = table_out;
            match_d   = match;
            glitch_d  = glitch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            samp_cnt   <= '0;
            gate_in    <= '0;
            shadow     <= '0;
            sflag      <= 1'b0;
            wr_pend    <= 1'b0;
            wr_idx     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_out  <= '0;
            match      <= 1'b0;
            glitch     <= 1'b0;
        end else begin
            settle_cnt <= settle_cnt_d;
            samp_cnt   <= samp_cnt_d;
            gate_in    <= code_d;
            shadow     <= shadow_d;
            sflag      <= sflag_d;
            wr_pend    <= wr_pend_d;
            wr_idx     <= wr_idx_d;
            busy       <= busy_d;
            done       <= done_d;
            table_out  <= table_d;
            match      <= match_d;
            glitch     <= glitch_d;
        end
    end

endmodule
